// File: rtl/mpq_param.sv
// mpq_param: parametrised binary-heap priority queue (max- or min-heap).
// Values are bulk-loaded into the heap array. Queue commands then run on it:
// build, extract, change key, insert, write (dump to RAM) and clear.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   data_valid/data load strobe and value, appended at position count+1 while idle
//   cmd_valid/cmd   command strobe and code (0 build .. 5 clear), sampled while idle
//   index/value     1-based position and key for change key, key for insert
//   busy            high while a command executes
//   RAM_valid/RAM_A/RAM_D  heap dump write port (0-based address)
//   done            one-cycle pulse when a write dump completes
//   ext_valid/ext_data  extracted root pulse, data held until the next extract
//   err             one-cycle pulse on a rejected load or command
//   count           current number of heap entries
module mpq_param #(
   parameter int DW       = 8,
   parameter int DEPTH    = 16,
   parameter int IW       = 8,
   parameter int MIN_MODE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          data_valid,
   input  logic [DW-1:0] data,
   input  logic          cmd_valid,
   input  logic [2:0]    cmd,
   input  logic [IW-1:0] index,
   input  logic [DW-1:0] value,
   output logic          busy,
   output logic          RAM_valid,
   output logic [IW-1:0] RAM_A,
   output logic [DW-1:0] RAM_D,
   output logic          done,
   output logic          ext_valid,
   output logic [DW-1:0] ext_data,
   output logic          err,
   output logic [IW-1:0] count
);

   typedef enum logic [2:0] {IDLE, BUILD, SIFT_DN, SIFT_UP, WRITE, FINISH} state_t;

   localparam int            HN      = 1 << IW;
   localparam logic [IW-1:0] ONE     = IW'(1);
   localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);

   // Position 0 is never used so heap positions index the array directly.
   logic [DW-1:0] heap_q [0:HN-1];

   state_t        state_q, state_d;
   logic [IW-1:0] count_q, count_d;
   logic [IW-1:0] pos_q, pos_d;      // current sift position
   logic [IW-1:0] bld_q, bld_d;      // current build root i
   logic [IW-1:0] wk_q, wk_d;        // write word counter
   logic          busy_q, busy_d;
   logic          ram_valid_q, ram_valid_d;
   logic [IW-1:0] ram_a_q, ram_a_d;
   logic [DW-1:0] ram_d_q, ram_d_d;
   logic          done_q, done_d;
   logic          ext_valid_q, ext_valid_d;
   logic [DW-1:0] ext_data_q, ext_data_d;
   logic          err_q, err_d;

   // Two heap write ports so a swap completes in one cycle.
   logic          we0, we1;
   logic [IW-1:0] wa0, wa1;
   logic [DW-1:0] wd0, wd1;

   logic [IW:0]   lc, rc;            // one extra bit so child positions never wrap
   logic [IW-1:0] sd_best, parent;
   logic [DW-1:0] sd_val;

   function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (MIN_MODE != 0) return a < b;
      else               return a > b;
   endfunction

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      pos_d       = pos_q;
      bld_d       = bld_q;
      wk_d        = wk_q;
      ram_valid_d = 1'b0;
      ram_a_d     = ram_a_q;
      ram_d_d     = ram_d_q;
      done_d      = 1'b0;
      ext_valid_d = 1'b0;
      ext_data_d  = ext_data_q;
      err_d       = 1'b0;
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;

      // Sift-down step: best of node and existing children; the right child
      // only wins if strictly better than the current best, so left wins ties.
      lc      = {pos_q, 1'b0};
      rc      = {pos_q, 1'b1};
      parent  = pos_q >> 1;
      sd_best = pos_q;
      sd_val  = heap_q[pos_q];
      if (lc <= {1'b0, count_q} && better(heap_q[lc[IW-1:0]], sd_val)) begin
         sd_best = lc[IW-1:0];
         sd_val  = heap_q[lc[IW-1:0]];
      end
      if (rc <= {1'b0, count_q} && better(heap_q[rc[IW-1:0]], sd_val)) begin
         sd_best = rc[IW-1:0];
         sd_val  = heap_q[rc[IW-1:0]];
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd)
                  3'd0: begin
                     if (count_q <= ONE) begin
                        state_d = FINISH;
                     end else begin
                        bld_d   = count_q >> 1;
                        pos_d   = count_q >> 1;
                        state_d = BUILD;
                     end
                  end
                  3'd1: begin
                     if (count_q == '0) begin
                        err_d = 1'b1;
                     end else begin
                        ext_data_d  = heap_q[ONE];
                        ext_valid_d = 1'b1;
                        we0 = 1'b1; wa0 = ONE; wd0 = heap_q[count_q];
                        count_d = count_q - ONE;
                        pos_d   = ONE;
                        state_d = SIFT_DN;
                     end
                  end
                  3'd2: begin
                     // A key change may only move an entry towards the root.
                     if (index == '0 || index > count_q || better(heap_q[index], value)) begin
                        err_d = 1'b1;
                     end else begin
                        we0 = 1'b1; wa0 = index; wd0 = value;
                        pos_d   = index;
                        state_d = SIFT_UP;
                     end
                  end
                  3'd3: begin
                     if (count_q == DEPTH_I) begin
                        err_d = 1'b1;
                     end else begin
                        we0 = 1'b1; wa0 = count_q + ONE; wd0 = value;
                        count_d = count_q + ONE;
                        pos_d   = count_q + ONE;
                        state_d = SIFT_UP;
                     end
                  end
                  3'd4: begin
                     wk_d    = '0;
                     state_d = WRITE;
                  end
                  3'd5: begin
                     count_d = '0;
                     state_d = FINISH;
                  end
                  default: err_d = 1'b1;
               endcase
            end else if (data_valid) begin
               if (count_q == DEPTH_I) begin
                  err_d = 1'b1;
               end else begin
                  we0 = 1'b1; wa0 = count_q + ONE; wd0 = data;
                  count_d = count_q + ONE;
               end
            end
         end
         BUILD, SIFT_DN: begin
            if (sd_best != pos_q) begin
               we0 = 1'b1; wa0 = pos_q;   wd0 = sd_val;
               we1 = 1'b1; wa1 = sd_best; wd1 = heap_q[pos_q];
               pos_d = sd_best;
            end else if (state_q == BUILD && bld_q > ONE) begin
               bld_d = bld_q - ONE;
               pos_d = bld_q - ONE;
            end else begin
               state_d = IDLE;
            end
         end
         SIFT_UP: begin
            if (pos_q > ONE && better(heap_q[pos_q], heap_q[parent])) begin
               we0 = 1'b1; wa0 = parent; wd0 = heap_q[pos_q];
               we1 = 1'b1; wa1 = pos_q;  wd1 = heap_q[parent];
               pos_d = parent;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (wk_q < count_q) begin
               ram_valid_d = 1'b1;
               ram_a_d     = wk_q;
               ram_d_d     = heap_q[wk_q + ONE];
               wk_d        = wk_q + ONE;
            end else begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         pos_q       <= '0;
         bld_q       <= '0;
         wk_q        <= '0;
         busy_q      <= 1'b0;
         ram_valid_q <= 1'b0;
         ram_a_q     <= '0;
         ram_d_q     <= '0;
         done_q      <= 1'b0;
         ext_valid_q <= 1'b0;
         ext_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         pos_q       <= pos_d;
         bld_q       <= bld_d;
         wk_q        <= wk_d;
         busy_q      <= busy_d;
         ram_valid_q <= ram_valid_d;
         ram_a_q     <= ram_a_d;
         ram_d_q     <= ram_d_d;
         done_q      <= done_d;
         ext_valid_q <= ext_valid_d;
         ext_data_q  <= ext_data_d;
         err_q       <= err_d;
      end
   end

   // Heap storage carries no reset; its contents are meaningless while count is 0.
   always_ff @(posedge clk) begin
      if (we0) heap_q[wa0] <= wd0;
      if (we1) heap_q[wa1] <= wd1;
   end

   assign busy      = busy_q;
   assign RAM_valid = ram_valid_q;
   assign RAM_A     = ram_a_q;
   assign RAM_D     = ram_d_q;
   assign done      = done_q;
   assign ext_valid = ext_valid_q;
   assign ext_data  = ext_data_q;
   assign err       = err_q;
   assign count     = count_q;

endmodule

// File: tb/tb_mpq_param.sv
// Bench for mpq_param: three instances (max/16, max/4, min/16) driven by a
// vector table, hand sequences and random operations checked against a
// software heap model.
module tb_mpq_param;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NI-1:0]       dv, cv, busy, rv, done, ev, er;
   logic [NI-1:0][7:0]  dat, idx, val, ra, rd, ed, cnt;
   logic [NI-1:0][2:0]  cmd;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mpq_param #(.DW(8), .DEPTH(g == 1 ? 4 : 16), .IW(8), .MIN_MODE(g == 2 ? 1 : 0)) u_dut (
         .clk(clk), .rst(rst),
         .data_valid(dv[g]), .data(dat[g]),
         .cmd_valid(cv[g]), .cmd(cmd[g]), .index(idx[g]), .value(val[g]),
         .busy(busy[g]), .RAM_valid(rv[g]), .RAM_A(ra[g]), .RAM_D(rd[g]),
         .done(done[g]), .ext_valid(ev[g]), .ext_data(ed[g]),
         .err(er[g]), .count(cnt[g])
      );
   end

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural heap model ----------------
   int mh [NI][256];
   int mc [NI];
   int mlast [NI];
   int mdep [NI] = '{16, 4, 16};
   int mmin [NI] = '{0, 0, 1};
   bit e_err;
   int e_ext;
   int exp_w [$];

   function automatic bit mbet(input int u, input int a, input int b);
      return (mmin[u] != 0) ? (a < b) : (a > b);
   endfunction

   task automatic mswap(input int u, input int a, input int b);
      int t;
      t = mh[u][a]; mh[u][a] = mh[u][b]; mh[u][b] = t;
   endtask

   task automatic msdn(input int u, input int p0);
      int p, b;
      p = p0;
      forever begin
         b = p;
         if (2*p <= mc[u] && mbet(u, mh[u][2*p], mh[u][b])) b = 2*p;
         if (2*p+1 <= mc[u] && mbet(u, mh[u][2*p+1], mh[u][b])) b = 2*p+1;
         if (b == p) break;
         mswap(u, p, b);
         p = b;
      end
   endtask

   task automatic msup(input int u, input int p0);
      int p;
      p = p0;
      while (p > 1 && mbet(u, mh[u][p], mh[u][p/2])) begin
         mswap(u, p, p/2);
         p = p / 2;
      end
   endtask

   // op 0..7 = command codes, 8 = load
   task automatic mop(input int u, input int op, input int ix, input int v);
      e_err = 0; e_ext = -1; exp_w.delete();
      case (op)
         8: if (mc[u] == mdep[u]) e_err = 1; else begin mc[u]++; mh[u][mc[u]] = v; end
         0: for (int i = mc[u] / 2; i >= 1; i--) msdn(u, i);
         1: if (mc[u] == 0) e_err = 1;
            else begin
               e_ext = mh[u][1]; mlast[u] = e_ext;
               mh[u][1] = mh[u][mc[u]]; mc[u]--; msdn(u, 1);
            end
         2: if (ix == 0 || ix > mc[u] || mbet(u, mh[u][ix], v)) e_err = 1;
            else begin mh[u][ix] = v; msup(u, ix); end
         3: if (mc[u] == mdep[u]) e_err = 1;
            else begin mc[u]++; mh[u][mc[u]] = v; msup(u, mc[u]); end
         4: for (int k = 1; k <= mc[u]; k++) exp_w.push_back(mh[u][k]);
         5: mc[u] = 0;
         default: e_err = 1;
      endcase
   endtask

   // ---------------- DUT driver ----------------
   bit a_err, a_busy, a_to;
   int a_ext, a_done, a_addr;
   int act_w [$];

   task automatic dop(input int u, input int op, input int ix, input int v,
                      input bit al, input int ld, input bit poke);
      int  n;
      bit  poked;
      if (op == 8) begin
         dv[u] = 1'b1; dat[u] = 8'(v);
      end else begin
         cv[u] = 1'b1; cmd[u] = 3'(op); idx[u] = 8'(ix); val[u] = 8'(v);
         if (al) begin dv[u] = 1'b1; dat[u] = 8'(ld); end
      end
      @(posedge clk); #1;
      dv[u] = 1'b0; cv[u] = 1'b0;
      a_err = 0; a_ext = -1; a_done = 0; a_busy = 0; a_to = 0; a_addr = 0;
      act_w.delete(); n = 0; poked = 0;
      forever begin
         if (poked) begin dv[u] = 1'b0; cv[u] = 1'b0; poked = 0; end
         if (er[u]) a_err = 1;
         if (ev[u]) a_ext = int'(ed[u]);
         if (done[u]) a_done++;
         if (rv[u]) begin
            if (int'(ra[u]) != act_w.size()) a_addr++;
            act_w.push_back(int'(rd[u]));
         end
         if (!busy[u]) break;
         a_busy = 1;
         // strobes while busy must be ignored (a clear here would be visible)
         if (poke && n == 0) begin
            dv[u] = 1'b1; dat[u] = 8'hAA; cv[u] = 1'b1; cmd[u] = 3'd5; poked = 1;
         end
         n++;
         if (n > 2000) begin a_to = 1; break; end
         @(posedge clk); #1;
      end
      dv[u] = 1'b0; cv[u] = 1'b0;
   endtask

   task automatic model_check(input int u, input int op, input string tag);
      chk({tag, "_timeout"}, int'(a_to), 0);
      chk({tag, "_err"}, int'(a_err), int'(e_err));
      chk({tag, "_busy"}, int'(a_busy), (op != 8 && !e_err) ? 1 : 0);
      chk({tag, "_ext"}, a_ext, e_ext);
      chk({tag, "_done"}, a_done, (op == 4 && !e_err) ? 1 : 0);
      chk({tag, "_nwords"}, act_w.size(), exp_w.size());
      for (int k = 0; k < act_w.size() && k < exp_w.size(); k++)
         chk($sformatf("%s_w%0d", tag, k), act_w[k], exp_w[k]);
      if (act_w.size() > 0) chk({tag, "_addr"}, a_addr, 0);
      chk({tag, "_count"}, int'(cnt[u]), mc[u]);
      chk({tag, "_hold"}, int'(ed[u]), mlast[u]);
   endtask

   task automatic run_op(input int u, input int op, input int ix, input int v,
                         input bit al, input int ld, input bit poke, input string tag);
      mop(u, op, ix, v);
      dop(u, op, ix, v, al, ld, poke);
      model_check(u, op, tag);
   endtask

   task automatic check_reset(input string tag);
      for (int u = 0; u < NI; u++) begin
         chk($sformatf("%s_u%0d_busy", tag, u), int'(busy[u]), 0);
         chk($sformatf("%s_u%0d_ramv", tag, u), int'(rv[u]), 0);
         chk($sformatf("%s_u%0d_rama", tag, u), int'(ra[u]), 0);
         chk($sformatf("%s_u%0d_ramd", tag, u), int'(rd[u]), 0);
         chk($sformatf("%s_u%0d_done", tag, u), int'(done[u]), 0);
         chk($sformatf("%s_u%0d_extv", tag, u), int'(ev[u]), 0);
         chk($sformatf("%s_u%0d_extd", tag, u), int'(ed[u]), 0);
         chk($sformatf("%s_u%0d_err", tag, u), int'(er[u]), 0);
         chk($sformatf("%s_u%0d_count", tag, u), int'(cnt[u]), 0);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int u; int op; int ix; int v;
      bit e_err; int e_cnt; int e_ext; int e_n; int e_w [5];
   } vec_t;
   vec_t tbl [$];

   task automatic add(input int u, input int op, input int ix, input int v,
                      input bit e, input int c, input int x, input int n,
                      input int w0, input int w1, input int w2, input int w3, input int w4);
      vec_t t;
      t.u = u; t.op = op; t.ix = ix; t.v = v; t.e_err = e; t.e_cnt = c; t.e_ext = x; t.e_n = n;
      t.e_w[0] = w0; t.e_w[1] = w1; t.e_w[2] = w2; t.e_w[3] = w3; t.e_w[4] = w4;
      tbl.push_back(t);
   endtask

   initial begin
      dv = '0; cv = '0; dat = '0; idx = '0; val = '0; cmd = '0;
      for (int u = 0; u < NI; u++) begin mc[u] = 0; mlast[u] = 0; end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      rst = 1'b0;
      @(posedge clk); #1;

      // max-heap, depth 16
      add(0, 8, 0, 3, 0, 1, -1, -1, 0, 0, 0, 0, 0);
      add(0, 8, 0, 1, 0, 2, -1, -1, 0, 0, 0, 0, 0);
      add(0, 8, 0, 4, 0, 3, -1, -1, 0, 0, 0, 0, 0);
      add(0, 8, 0, 1, 0, 4, -1, -1, 0, 0, 0, 0, 0);
      add(0, 8, 0, 5, 0, 5, -1, -1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 5, -1, -1, 0, 0, 0, 0, 0);
      add(0, 4, 0, 0, 0, 5, -1,  5, 5, 3, 4, 1, 1);
      add(0, 1, 0, 0, 0, 4,  5, -1, 0, 0, 0, 0, 0);
      add(0, 4, 0, 0, 0, 4, -1,  4, 4, 3, 1, 1, 0);
      add(0, 3, 0, 9, 0, 5, -1, -1, 0, 0, 0, 0, 0);
      add(0, 4, 0, 0, 0, 5, -1,  5, 9, 4, 1, 1, 3);
      add(0, 2, 4, 6, 0, 5, -1, -1, 0, 0, 0, 0, 0);
      add(0, 4, 0, 0, 0, 5, -1,  5, 9, 6, 1, 4, 3);
      // max-heap, depth 4: rejections
      add(1, 8, 0, 10, 0, 1, -1, -1, 0, 0, 0, 0, 0);
      add(1, 8, 0, 20, 0, 2, -1, -1, 0, 0, 0, 0, 0);
      add(1, 8, 0, 30, 0, 3, -1, -1, 0, 0, 0, 0, 0);
      add(1, 8, 0, 40, 0, 4, -1, -1, 0, 0, 0, 0, 0);
      add(1, 8, 0, 50, 1, 4, -1, -1, 0, 0, 0, 0, 0);
      add(1, 3, 0, 7,  1, 4, -1, -1, 0, 0, 0, 0, 0);
      add(1, 2, 0, 99, 1, 4, -1, -1, 0, 0, 0, 0, 0);
      add(1, 2, 5, 99, 1, 4, -1, -1, 0, 0, 0, 0, 0);
      add(1, 2, 1, 5,  1, 4, -1, -1, 0, 0, 0, 0, 0);
      add(1, 6, 0, 0,  1, 4, -1, -1, 0, 0, 0, 0, 0);
      add(1, 5, 0, 0,  0, 0, -1, -1, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0,  1, 0, -1, -1, 0, 0, 0, 0, 0);
      // min-heap, depth 16
      add(2, 8, 0, 3, 0, 1, -1, -1, 0, 0, 0, 0, 0);
      add(2, 8, 0, 1, 0, 2, -1, -1, 0, 0, 0, 0, 0);
      add(2, 8, 0, 4, 0, 3, -1, -1, 0, 0, 0, 0, 0);
      add(2, 8, 0, 1, 0, 4, -1, -1, 0, 0, 0, 0, 0);
      add(2, 8, 0, 5, 0, 5, -1, -1, 0, 0, 0, 0, 0);
      add(2, 0, 0, 0, 0, 5, -1, -1, 0, 0, 0, 0, 0);
      add(2, 4, 0, 0, 0, 5, -1,  5, 1, 1, 4, 3, 5);
      add(2, 1, 0, 0, 0, 4,  1, -1, 0, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         run_op(tbl[i].u, tbl[i].op, tbl[i].ix, tbl[i].v, 0, 0, 0, $sformatf("v%0d", i));
         chk($sformatf("v%0d_tbl_err", i), int'(a_err), int'(tbl[i].e_err));
         chk($sformatf("v%0d_tbl_cnt", i), int'(cnt[tbl[i].u]), tbl[i].e_cnt);
         if (tbl[i].e_err) chk($sformatf("v%0d_tbl_busy", i), int'(a_busy), 0);
         if (tbl[i].e_ext >= 0) chk($sformatf("v%0d_tbl_ext", i), a_ext, tbl[i].e_ext);
         if (tbl[i].e_n >= 0) begin
            chk($sformatf("v%0d_tbl_done", i), a_done, 1);
            chk($sformatf("v%0d_tbl_n", i), act_w.size(), tbl[i].e_n);
            for (int k = 0; k < tbl[i].e_n && k < act_w.size(); k++)
               chk($sformatf("v%0d_tbl_w%0d", i, k), act_w[k], tbl[i].e_w[k]);
         end
      end

      // command has priority over a simultaneous load; strobes while busy ignored
      run_op(0, 4, 0, 0, 1, 77, 1, "prio_write");
      run_op(0, 1, 0, 0, 1, 88, 1, "prio_extract");

      // asynchronous reset in the middle of a build
      cv[0] = 1'b1; cmd[0] = 3'd0;
      @(posedge clk); #1;
      cv[0] = 1'b0;
      chk("midbuild_busy", int'(busy[0]), 1);
      #2 rst = 1'b1;
      #1;
      check_reset("midrst");
      rst = 1'b0;
      for (int u = 0; u < NI; u++) begin mc[u] = 0; mlast[u] = 0; end
      @(posedge clk); #1;
      run_op(0, 4, 0, 0, 0, 0, 0, "postrst_write");
      chk("postrst_nwords", act_w.size(), 0);
      chk("postrst_done", a_done, 1);

      // random operations against the model
      for (int u = 0; u < NI; u++) begin
         int nops;
         nops = (u == 1) ? 80 : 200;
         for (int i = 0; i < nops; i++) begin
            int r, op, ix, v;
            r  = int'($urandom_range(0, 99));
            if      (r < 40) op = 8;
            else if (r < 48) op = 0;
            else if (r < 60) op = 1;
            else if (r < 70) op = 3;
            else if (r < 82) op = 2;
            else if (r < 90) op = 4;
            else if (r < 93) op = 5;
            else if (r < 96) op = 6 + int'($urandom_range(0, 1));
            else             op = 8;
            ix = int'($urandom_range(0, mc[u] + 1));
            v  = int'($urandom_range(0, 20));
            run_op(u, op, ix, v, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)),
                   ($urandom_range(0, 3) == 0), $sformatf("r%0d_%0d", u, i));
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
